axi_sram_slave: RTL
===================

Name: axi_sram_slave

Overview:
- Parametrised AXI4 memory slave: the next-generation simulation/FPGA memory model behind the core's instruction and data buses.
- Generalises the fixed single-beat slave in four ways:
  - configurable data width, depth, base address and latency;
  - AW and W channels accepted independently;
  - INCR bursts with rlast/wlast;
  - internal storage array with SLVERR for out-of-range accesses.
- Sits between the core's AXI arbiter and nothing else; it is a leaf.

Parameters:
- DATA_W, 32, data width in bits; legal values 32 or 64.
- ADDR_W, 32, address width.
- DEPTH, 1024, number of DATA_W-bit words stored.
- BASE, 32'h8000_0000, byte address of word 0.
- READ_LAT, 1, idle cycles between AR handshake and first rvalid (0..15).
- WRITE_LAT, 1, idle cycles between the last W handshake and bvalid (0..15).
- LFSR_SEED, 16'hACE1, seed for the optional random-delay generator.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- araddr, in, ADDR_W, read address.
- arlen, in, 8, beats minus 1.
- arburst, in, 2, burst type.
- arvalid, in, 1 / arready, out, 1: AR handshake.
- rdata, out, DATA_W, read data.
- rresp, out, 2, read response.
- rlast, out, 1, last read beat.
- rvalid, out, 1 / rready, in, 1: R handshake.
- awaddr, in, ADDR_W, write address.
- awlen, in, 8, beats minus 1.
- awburst, in, 2, burst type.
- awvalid, in, 1 / awready, out, 1: AW handshake.
- wdata, in, DATA_W, write data.
- wstrb, in, DATA_W/8, byte enables.
- wlast, in, 1, last write beat.
- wvalid, in, 1 / wready, out, 1: W handshake.
- bresp, out, 2, write response.
- bvalid, out, 1 / bready, in, 1: B handshake.

Behaviour:
- Reset (rst_n low, asynchronous):
  - every ready/valid output 0; rdata 0; rresp 00; bresp 00; rlast 0;
  - FSM to IDLE; beat counters 0; the storage array is not cleared.
- FSM states: IDLE, R_WAIT, R_DATA, W_COLLECT, W_WAIT, W_RESP.
- IDLE:
  - arready = 1, awready = 1 (registered, asserted the cycle after entering IDLE).
  - AR has priority: if arvalid and awvalid are both high in the same cycle, accept AR only; awready drops.
  - AR handshake: latch addr/len, load delay counter with READ_LAT, go to R_WAIT.
  - AW handshake alone: latch addr/len, go to W_COLLECT.
- R_WAIT: decrement the counter; at 0 go to R_DATA, present beat 0 with rvalid = 1.
- R_DATA:
  - rdata, rresp and rlast are held stable while rvalid && !rready.
  - On handshake: address += DATA_W/8; next beat presented the following cycle with no bubble.
  - rlast = 1 on beat arlen.
  - Handshake with rlast: go to IDLE, rvalid drops.
- W_COLLECT:
  - wready = 1; each W handshake writes only the bytes enabled by wstrb, then address += DATA_W/8.
  - W beats arriving before AW are not accepted: wready = 0 outside W_COLLECT.
  - Handshake with wlast, or with beat count == awlen: load WRITE_LAT and go to W_WAIT.
  - wlast early or late relative to awlen: the burst terminates at whichever comes first, and bresp = SLVERR.
- W_WAIT: decrement the counter; at 0 go to W_RESP with bvalid = 1.
- W_RESP: hold bresp until bready; then go to IDLE.
- Range check, per beat:
  - word index = (addr − BASE) >> log2(DATA_W/8).
  - addr < BASE or index >= DEPTH → that beat is an error beat: read returns 0 with rresp SLVERR (2'b10); write is suppressed.
  - bresp = SLVERR if any beat in the burst errored.
- Burst type and alignment:
  - arburst/awburst other than INCR (2'b01) is treated as INCR with SLVERR on every beat.
  - Unaligned addresses: low bits are ignored for indexing.
- The address increment wraps at 2^ADDR_W; wrapped beats fall out of range and return SLVERR.
- READ_LAT = 0: first rvalid appears in the cycle after the AR handshake (minimum one-cycle latency).
- rready held high throughout a burst gives one beat per cycle.

Optional Feature:
- Macro SRAM_RAND_DELAY_EN.
- Defined:
  - a 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded with LFSR_SEED on reset, advances every cycle;
  - its low 4 bits are added to READ_LAT/WRITE_LAT at each load;
  - arready/awready are additionally gated low while LFSR bit 0 is set in IDLE.
- Undefined: latencies fixed exactly at READ_LAT/WRITE_LAT; no LFSR logic is present.

Decomposition:
- Package sram_pkg:
  - response codes RESP_OKAY 2'b00, RESP_SLVERR 2'b10;
  - BURST_INCR 2'b01;
  - FSM state enum;
  - LFSR tap constant.
- One sub-module: sram_lfsr, instantiated only under SRAM_RAND_DELAY_EN.

Test Plan:
- Write 0xDEADBEEF, wstrb 4'hF, to 0x8000_0010; then read it, READ_LAT = 1 → rvalid 2 cycles after AR handshake, rdata 0xDEADBEEF, rresp 00, rlast 1.
- Partial write wstrb 4'b0010, wdata 0x0000_AB00, over 0xDEADBEEF → readback 0xDEADABEF.
- 4-beat INCR read (arlen 3) from 0x8000_0000 with rready toggled every other cycle → 4 beats, data stable while stalled, rlast only on beat 3.
- AW issued 3 cycles before W → wready stays 0 until W_COLLECT; 2-beat burst writes consecutive words; bresp 00.
- Read at BASE + DEPTH*4 = 0x8000_1000 → rdata 0, rresp 10; a write there leaves memory unchanged and bresp 10.
- arvalid and awvalid raised in the same cycle → read completes first, then the write; assert rst_n low mid-burst → all valids 0 immediately, FSM in IDLE.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the AXI4 SRAM slave: response and burst codes,
// controller state encoding and the tap mask of the optional delay LFSR.
package sram_pkg;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  BURST_INCR  = 2'b01;

    // Taps 16,14,13,11 of a 16-bit Fibonacci LFSR, as a bit mask on [15:0].
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        R_WAIT    = 3'd1,
        R_DATA    = 3'd2,
        W_COLLECT = 3'd3,
        W_WAIT    = 3'd4,
        W_RESP    = 3'd5
    } sram_state_e;

    // Map a per-beat or per-burst error flag onto an AXI response code.
    function automatic logic [1:0] resp_of(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/sram_lfsr.sv
// Free-running 16-bit Fibonacci LFSR supplying random extra latency for the
// SRAM slave. The module only exists when SRAM_RAND_DELAY_EN is defined.
`ifdef SRAM_RAND_DELAY_EN
module sram_lfsr
    import sram_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        fb_s;

    // Next LFSR value: shift left, feed the XOR of the tapped bits into bit 0.
    always_comb begin
        fb_s   = ^(lfsr_q & LFSR_TAPS);
        lfsr_d = {lfsr_q[14:0], fb_s};
    end

    // LFSR register, reseeded on reset and advanced every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q[3:0];

endmodule
`endif

// File: rtl/axi_sram_slave.sv
// AXI4 memory slave with internal storage, INCR bursts, independent AW/W
// acceptance and SLVERR for out-of-range or non-INCR beats.
// Optional feature: define SRAM_RAND_DELAY_EN to add LFSR-driven random extra
// latency and random arready/awready back-pressure in IDLE.
module axi_sram_slave
    import sram_pkg::*;
#(
    parameter int unsigned     DATA_W    = 32,
    parameter int unsigned     ADDR_W    = 32,
    parameter int unsigned     DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE    = 32'h8000_0000,
    parameter int unsigned     READ_LAT  = 1,
    parameter int unsigned     WRITE_LAT = 1,
    parameter logic [15:0]     LFSR_SEED = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic [7:0]            arlen,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic [7:0]            awlen,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready
);

    localparam int unsigned       STRB_W  = DATA_W / 8;
    localparam int unsigned       SHIFT   = $clog2(STRB_W);
    localparam int unsigned       IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(STRB_W);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    // True when a byte address maps onto a stored word.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = (a - BASE) >> SHIFT;
        if (a < BASE) begin
            return 1'b0;
        end else begin
            return (off < DEPTH_A);
        end
    endfunction

    // Word index of a byte address; low (sub-word) address bits are ignored.
    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE) >> SHIFT);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    sram_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        beat_q, beat_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              burst_err_q, burst_err_d;
    logic              werr_q, werr_d;
    logic              arready_q, arready_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              rvalid_q, rvalid_d;
    logic              rlast_q, rlast_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;

    logic              ar_hs_s, aw_hs_s, w_hs_s, r_hs_s, b_hs_s;
    logic              present_s;
    logic [ADDR_W-1:0] beat_addr_s;
    logic              mem_we_s;
    logic              wbeat_err_s;
    logic              werr_acc_s;
    logic              wend_s;
    logic [4:0]        rd_lat_s, wr_lat_s;
    logic              gate_s;

`ifdef SRAM_RAND_DELAY_EN
    logic [3:0]        lfsr_s;

    sram_lfsr #(
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .lfsr_o (lfsr_s)
    );

    assign rd_lat_s = 5'(READ_LAT) + {1'b0, lfsr_s};
    assign wr_lat_s = 5'(WRITE_LAT) + {1'b0, lfsr_s};
    assign gate_s   = lfsr_s[0];
`else
    logic [15:0]       unused_seed_s;

    assign unused_seed_s = LFSR_SEED;
    assign rd_lat_s      = 5'(READ_LAT);
    assign wr_lat_s      = 5'(WRITE_LAT);
    assign gate_s        = 1'b0;
`endif

    // AW is masked while arvalid is high so that AR always wins a tie.
    assign arready = arready_q & ~gate_s;
    assign awready = awready_q & ~gate_s & ~arvalid;
    assign wready  = wready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;

    assign ar_hs_s = arvalid & arready;
    assign aw_hs_s = awvalid & awready;
    assign w_hs_s  = wvalid & wready_q;
    assign r_hs_s  = rvalid_q & rready;
    assign b_hs_s  = bvalid_q & bready;

    // Next-state, burst bookkeeping and registered channel outputs.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        beat_d      = beat_q;
        cnt_d       = cnt_q;
        burst_err_d = burst_err_q;
        werr_d      = werr_q;
        rvalid_d    = rvalid_q;
        rlast_d     = rlast_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        present_s   = 1'b0;
        beat_addr_s = addr_q;
        mem_we_s    = 1'b0;
        wbeat_err_s = 1'b0;
        werr_acc_s  = werr_q;
        wend_s      = 1'b0;

        case (state_q)
            IDLE: begin
                if (ar_hs_s) begin
                    addr_d      = araddr;
                    len_d       = arlen;
                    beat_d      = 8'd0;
                    burst_err_d = (arburst != BURST_INCR);
                    if (rd_lat_s == 5'd0) begin
                        state_d     = R_DATA;
                        present_s   = 1'b1;
                        beat_addr_s = araddr;
                        rlast_d     = (arlen == 8'd0);
                    end else begin
                        state_d = R_WAIT;
                        cnt_d   = rd_lat_s - 5'd1;
                    end
                end else if (aw_hs_s) begin
                    addr_d      = awaddr;
                    len_d       = awlen;
                    beat_d      = 8'd0;
                    burst_err_d = (awburst != BURST_INCR);
                    werr_d      = (awburst != BURST_INCR);
                    state_d     = W_COLLECT;
                end else begin
                    state_d = IDLE;
                end
            end
            R_WAIT: begin
                if (cnt_q == 5'd0) begin
                    state_d     = R_DATA;
                    present_s   = 1'b1;
                    beat_addr_s = addr_q;
                    rlast_d     = (len_q == 8'd0);
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            R_DATA: begin
                if (r_hs_s) begin
                    if (rlast_q) begin
                        state_d  = IDLE;
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                    end else begin
                        addr_d      = addr_q + STEP;
                        beat_d      = beat_q + 8'd1;
                        present_s   = 1'b1;
                        beat_addr_s = addr_q + STEP;
                        rlast_d     = ((beat_q + 8'd1) == len_q);
                    end
                end else begin
                    state_d = R_DATA;
                end
            end
            W_COLLECT: begin
                if (w_hs_s) begin
                    wbeat_err_s = burst_err_q | ~in_range(addr_q);
                    mem_we_s    = ~wbeat_err_s;
                    wend_s      = wlast | (beat_q == len_q);
                    // A wlast that disagrees with awlen also flags the burst.
                    werr_acc_s  = werr_q | wbeat_err_s | (wlast != (beat_q == len_q));
                    werr_d      = werr_acc_s;
                    if (wend_s) begin
                        if (wr_lat_s == 5'd0) begin
                            state_d  = W_RESP;
                            bvalid_d = 1'b1;
                            bresp_d  = resp_of(werr_acc_s);
                        end else begin
                            state_d = W_WAIT;
                            cnt_d   = wr_lat_s - 5'd1;
                        end
                    end else begin
                        addr_d = addr_q + STEP;
                        beat_d = beat_q + 8'd1;
                    end
                end else begin
                    state_d = W_COLLECT;
                end
            end
            W_WAIT: begin
                if (cnt_q == 5'd0) begin
                    state_d  = W_RESP;
                    bvalid_d = 1'b1;
                    bresp_d  = resp_of(werr_q);
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            W_RESP: begin
                if (b_hs_s) begin
                    state_d  = IDLE;
                    bvalid_d = 1'b0;
                end else begin
                    state_d = W_RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Load the beat being presented; error beats read as zero.
        if (present_s) begin
            rvalid_d = 1'b1;
            if (burst_err_d || !in_range(beat_addr_s)) begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end else begin
                rdata_d = mem[word_idx(beat_addr_s)];
                rresp_d = RESP_OKAY;
            end
        end else begin
            rvalid_d = rvalid_d;
        end

        arready_d = (state_d == IDLE);
        awready_d = (state_d == IDLE);
        wready_d  = (state_d == W_COLLECT);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= 8'd0;
            beat_q      <= 8'd0;
            cnt_q       <= 5'd0;
            burst_err_q <= 1'b0;
            werr_q      <= 1'b0;
            arready_q   <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= RESP_OKAY;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            cnt_q       <= cnt_d;
            burst_err_q <= burst_err_d;
            werr_q      <= werr_d;
            arready_q   <= arready_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            rvalid_q    <= rvalid_d;
            rlast_q     <= rlast_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
        end
    end

    // Storage write port: byte-masked, never reset, suppressed on error beats.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (wstrb[b]) begin
                    mem[word_idx(addr_q)][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
